// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory arbiter.
// Grant owner encoding and byte-to-word address translation.
`ifndef XLEN
`define XLEN 32
`endif

package mem_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } gnt_t;

  localparam int WORD_OFF = 2;

  function automatic logic [31:0] byte2word(
    input logic [31:0] addr,
    input int unsigned idx_w
  );
    return (addr >> WORD_OFF) & ((32'd1 << idx_w) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_rr_prio.sv
// Data-first priority with a streak guard that lets
// a waiting fetch in after MAX_DSTREAK data grants.
module mem_rr_prio #(
  parameter int MAX_DSTREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  output logic sel_if,
  output logic sel_d
);

  localparam int CW = $clog2(MAX_DSTREAK + 1);
  localparam logic [CW-1:0] DMAX = CW'(MAX_DSTREAK);

  logic [CW-1:0] dstreak;
  logic          guard;

  assign guard  = if_req && (dstreak == DMAX);
  assign sel_d  = !rst && d_req && !guard;
  assign sel_if = !rst && if_req && !sel_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      dstreak <= '0;
    end else if (!if_req || sel_if) begin
      dstreak <= '0;
    end else if (sel_d && dstreak != DMAX) begin
      dstreak <= dstreak + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store,
// returning registered read data one cycle after grant.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int XLEN        = `XLEN,
  parameter int IDX_W       = 10,
  parameter int MAX_DSTREAK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_err,
  output logic            mem_read_en,
  output logic            mem_write_en,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  logic            sel_if;
  logic            sel_d;
  logic            d_mis;
  logic            d_rsp;
  logic [XLEN-1:0] sel_addr;
  gnt_t            owner;
  gnt_t            last_gnt;
  logic            rsp_if_v;
  logic [XLEN-1:0] rsp_if_data;
  logic            rsp_d_v;
  logic [XLEN-1:0] rsp_d_data;
  logic            rsp_d_err;

  mem_rr_prio #(
    .MAX_DSTREAK(MAX_DSTREAK)
  ) u_prio (
    .clk   (clk),
    .rst   (rst),
    .if_req(if_req),
    .d_req (d_req),
    .sel_if(sel_if),
    .sel_d (sel_d)
  );

  assign d_mis = |d_addr[1:0];
  // Misaligned data grants still answer, with an error and no memory touch.
  assign d_rsp = sel_d && (d_mis || !d_we);

  always_comb begin
    owner = GNT_NONE;
    unique case (1'b1)
      sel_if:  owner = GNT_IF;
      sel_d:   owner = GNT_D;
      default: owner = GNT_NONE;
    endcase
  end

  assign sel_addr     = sel_d ? d_addr : if_addr;
  assign mem_addr     = XLEN'(byte2word(32'(sel_addr), IDX_W));
  assign mem_wdata    = sel_d ? d_wdata : '0;
  assign mem_read_en  = sel_if || (sel_d && !d_we && !d_mis);
  assign mem_write_en = sel_d && d_we && !d_mis;

  assign if_gnt = sel_if;
  assign d_gnt  = sel_d;

  // A fetch grant is the only GNT_IF source and always returns data.
  assign rsp_if_v = (last_gnt == GNT_IF);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt    <= GNT_NONE;
      rsp_if_data <= '0;
      rsp_d_v     <= 1'b0;
      rsp_d_data  <= '0;
      rsp_d_err   <= 1'b0;
    end else begin
      last_gnt  <= owner;
      rsp_d_v   <= d_rsp;
      rsp_d_err <= sel_d && d_mis;
      if (sel_if)
        rsp_if_data <= mem_rdata;
      if (d_rsp)
        rsp_d_data <= d_mis ? '0 : mem_rdata;
    end
  end

  // Responses are hidden while reset is high so a pending one is dropped.
  assign if_rvalid = rsp_if_v && !rst;
  assign if_rdata  = rst ? '0 : rsp_if_data;
  assign d_rvalid  = rsp_d_v && !rst;
  assign d_rdata   = rst ? '0 : rsp_d_data;
  assign d_err     = rsp_d_err && !rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural
// word memory standing in for main_memory.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem_bank [1024];

  int total;
  int bad;

  mem_arbiter #(
    .XLEN(32),
    .IDX_W(10),
    .MAX_DSTREAK(4)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_gnt      (if_gnt),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .d_err       (d_err),
    .mem_read_en (mem_read_en),
    .mem_write_en(mem_write_en),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem_bank[mem_addr[9:0]];

  always @(posedge clk)
    if (mem_write_en)
      mem_bank[mem_addr[9:0]] <= mem_wdata;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 1024; i++) mem_bank[i] = 32'h0;
    mem_bank[4] = 32'hDEADBEEF;
    mem_bank[8] = 32'h000055AA;
    rst     = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h10;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h20;
    d_wdata = 32'h0;
    step();
    step();
    #1;
    check("rst_if_gnt", 32'(if_gnt), 32'd0);
    check("rst_d_gnt", 32'(d_gnt), 32'd0);
    check("rst_rd_en", 32'(mem_read_en), 32'd0);
    rst = 1'b0;
    idle();
    step();
    check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_err", 32'(d_err), 32'd0);

    if_req = 1'b1;
    if_addr = 32'h10;
    #1;
    check("f_gnt", 32'(if_gnt), 32'd1);
    check("f_addr", mem_addr, 32'd4);
    check("f_rd_en", 32'(mem_read_en), 32'd1);
    step();
    idle();
    #1;
    check("f_rvalid", 32'(if_rvalid), 32'd1);
    check("f_rdata", if_rdata, 32'hDEADBEEF);
    check("f_no_drv", 32'(d_rvalid), 32'd0);
    step();
    check("f_pulse", 32'(if_rvalid), 32'd0);

    if_req = 1'b1;
    if_addr = 32'h1012;
    #1;
    check("f_mis_addr", mem_addr, 32'd4);
    step();
    idle();

    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h20;
    d_wdata = 32'h1234;
    #1;
    check("st_gnt", 32'(d_gnt), 32'd1);
    check("st_wr_en", 32'(mem_write_en), 32'd1);
    check("st_addr", mem_addr, 32'd8);
    check("st_wdata", mem_wdata, 32'h1234);
    step();
    d_we = 1'b0;
    #1;
    check("st_no_rvalid", 32'(d_rvalid), 32'd0);
    check("ld_rd_en", 32'(mem_read_en), 32'd1);
    step();
    idle();
    #1;
    check("ld_rvalid", 32'(d_rvalid), 32'd1);
    check("ld_rdata", d_rdata, 32'h1234);
    step();

    if_req = 1'b1;
    if_addr = 32'h10;
    d_req = 1'b1;
    d_addr = 32'h20;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("starve_%0d", i),
            {30'd0, if_gnt, d_gnt},
            (i % 5 == 4) ? 32'd2 : 32'd1);
      check($sformatf("excl_%0d", i),
            32'(if_rvalid && d_rvalid), 32'd0);
      step();
    end
    idle();
    step();

    d_req = 1'b1;
    d_addr = 32'h22;
    #1;
    check("mld_gnt", 32'(d_gnt), 32'd1);
    check("mld_rd_en", 32'(mem_read_en), 32'd0);
    step();
    idle();
    #1;
    check("mld_rvalid", 32'(d_rvalid), 32'd1);
    check("mld_err", 32'(d_err), 32'd1);
    check("mld_rdata", d_rdata, 32'd0);
    step();
    check("mld_err_clr", 32'(d_err), 32'd0);

    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h21;
    d_wdata = 32'hFFFF;
    #1;
    check("mst_gnt", 32'(d_gnt), 32'd1);
    check("mst_wr_en", 32'(mem_write_en), 32'd0);
    step();
    idle();
    #1;
    check("mst_rvalid", 32'(d_rvalid), 32'd1);
    check("mst_err", 32'(d_err), 32'd1);
    check("mst_mem", mem_bank[8], 32'h1234);
    step();

    if_req = 1'b1;
    d_req = 1'b1;
    d_addr = 32'h20;
    step();
    step();
    rst = 1'b1;
    #1;
    check("mrst_if_gnt", 32'(if_gnt), 32'd0);
    check("mrst_d_gnt", 32'(d_gnt), 32'd0);
    check("mrst_d_rvalid", 32'(d_rvalid), 32'd0);
    check("mrst_rd_en", 32'(mem_read_en), 32'd0);
    step();
    rst = 1'b0;
    idle();
    #1;
    check("mrst_streak", 32'(u_dut.u_prio.dstreak), 32'd0);
    check("mrst_rvalid2", 32'(d_rvalid), 32'd0);
    check("mrst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("mrst_rdata", d_rdata, 32'd0);
    d_req = 1'b1;
    d_addr = 32'h20;
    #1;
    check("post_gnt", 32'(d_gnt), 32'd1);
    step();
    idle();
    #1;
    check("post_rvalid", 32'(d_rvalid), 32'd1);
    check("post_rdata", d_rdata, 32'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single shared access path of `main_memory` between the instruction-fetch requester (IF stage) and the load/store requester (MEM stage). It grants one access per cycle under data priority with a starvation guard, and converts byte addresses to word indices. It drives the memory's enables, address and write data, and returns registered read data to each requester with fixed one-cycle latency. It sits between the pipeline stages and `main_memory` in the core top level.

## Interface
Parameters:
- `XLEN`, default `` `XLEN `` (32): data and address width.
- `IDX_W`, default 10: word-index width. `2**IDX_W` must be ≤ `` `ADDR_LEN ``.
- `MAX_DSTREAK`, default 4: maximum consecutive data grants while `if_req` is pending.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `if_req`  in  1  fetch request; held until `if_gnt`.
- `if_addr`  in  XLEN  fetch byte address.
- `if_gnt`  out  1  fetch accepted this cycle.
- `if_rvalid`  out  1  fetch data valid.
- `if_rdata`  out  XLEN  fetched instruction.
- `d_req`  in  1  data request; held until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  XLEN  data byte address.
- `d_wdata`  in  XLEN  store data.
- `d_gnt`  out  1  data accepted this cycle.
- `d_rvalid`  out  1  load data (or error) valid.
- `d_rdata`  out  XLEN  load data.
- `d_err`  out  1  misaligned access, qualified by `d_rvalid`.
- `mem_read_en`  out  1  memory read enable.
- `mem_write_en`  out  1  memory write enable.
- `mem_addr`  out  XLEN  word index, zero-extended.
- `mem_wdata`  out  XLEN  write data.
- `mem_rdata`  in  XLEN  combinational read data from memory.

## Operation
- Requester contract: a request is held with stable address and data until its grant. The grant (`*_gnt`) is combinational from the request and the arbiter's registered state.
- Arbitration, one grant per cycle:
  - Only one request: that request is granted.
  - Both requesting: data wins, unless `dstreak == MAX_DSTREAK`; then fetch wins.
- Streak counter `dstreak`, clog2(MAX_DSTREAK+1) bits:
  - Increments on a data grant while `if_req` is high, saturating at `MAX_DSTREAK`.
  - Clears on any fetch grant, or on any cycle where `if_req` is low.
- Address translation: `mem_addr = {0, addr[IDX_W+1:2]}`. Bits above `IDX_W+1` are ignored.
- Fetch misalignment: `if_addr[1:0]` is ignored, i.e. forced to a word boundary.
- Data misalignment: a data request with `d_addr[1:0] != 0` is granted without touching memory (`mem_read_en` = `mem_write_en` = 0). Next cycle: `d_rvalid` = 1, `d_err` = 1, `d_rdata` = 0. This applies to stores too.
- Granted load or fetch:
  - `mem_read_en` = 1 in the grant cycle.
  - `mem_rdata` is captured into the requester's response register.
  - The matching `*_rvalid` = 1 the next cycle.
- Granted aligned store:
  - `mem_write_en` = 1 and `mem_wdata = d_wdata` in the grant cycle.
  - No `d_rvalid`; the store is complete at grant.
- No grant: `mem_read_en` = `mem_write_en` = 0. `mem_addr`/`mem_wdata` are don't-care but must be driven from the fetch path (no latches).
- State: the response registers are the sequential core.
  - `rsp_if_v`, `rsp_if_data`.
  - `rsp_d_v`, `rsp_d_data`, `rsp_d_err`.
  - `dstreak`.
  - Grant-owner enum `GNT_NONE` / `GNT_IF` / `GNT_D`, registered as `last_gnt` for debug visibility.

## Timing
- Reset values: all `*_rvalid`, `d_err`, `*_rdata` = 0; `dstreak` = 0; `last_gnt` = `GNT_NONE`.
- Outputs during `rst`: grants and memory enables are forced 0 while `rst` is high.
- Latency: read data arrives exactly 1 cycle after grant. `*_rvalid` is a single-cycle pulse per grant.
- Throughput: one access per cycle. Back-to-back grants to the same or alternating requesters are allowed with no bubble.
- Simultaneous events:
  - A fetch grant and a data response may occur in the same cycle, and vice versa.
  - Both `*_rvalid` are never high together: at most one grant per cycle.
- Store followed by a load to the same word in the next cycle returns the new data, because the write commits at the clock edge.
- Reset mid-operation: a grant issued in the cycle `rst` rises is discarded, with no `rvalid` afterwards. A pending response is dropped.

## Structure
- Shared package `mem_pkg`:
  - Grant-owner enum `gnt_t` (`GNT_NONE`, `GNT_IF`, `GNT_D`).
  - Constant `WORD_OFF` = 2.
  - Function `byte2word(addr)`.
- Sub-module `mem_rr_prio`: holds the combinational priority decision plus the `dstreak` counter, and outputs `sel_if`/`sel_d`.
- The top level holds the muxing and response registers.

## Test plan
- Single fetch `if_addr=0x10` with `mem_bank[4]=0xDEADBEEF` → `if_gnt` in cycle T, `mem_addr=4`, `if_rvalid` with `if_rdata=0xDEADBEEF` at T+1.
- Store `d_addr=0x20`, `d_wdata=0x1234` at T, then load `0x20` at T+1 → `mem_write_en` at T, `d_rvalid` at T+2 with `d_rdata=0x1234`.
- Starvation guard, `MAX_DSTREAK=4`, `if_req` and `d_req` held continuously → grant pattern D,D,D,D,I,D,D,D,D,I.
- Misaligned load `d_addr=0x22` → `d_gnt`, `mem_read_en=0`, next cycle `d_rvalid=1`, `d_err=1`, `d_rdata=0`.
- Misaligned store `d_addr=0x21` → `d_gnt`, `mem_write_en=0`, no memory change (`mem_bank[8]` unchanged), next cycle `d_rvalid=1`, `d_err=1`.
- `rst` asserted in the cycle after a load grant → no `d_rvalid`, all outputs 0, `dstreak=0`, and a first request after reset is granted normally.
